// File: rtl/mouse_limit_clamp.sv
// Clamps raw mouse positions to programmable X/Y limits.
// Pipeline: stage 1 compares against the limits, stage 2 clamps, then the output register.
module mouse_limit_clamp #(
    parameter int unsigned DEFAULT_MAX_X = 800,
    parameter int unsigned DEFAULT_MAX_Y = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] value,
    input  logic        setmax_x,
    input  logic        setmax_y,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        pos_valid,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        pos_valid_out,
    output logic        edge_x,
    output logic        edge_y,
    output logic        moved,
    output logic        limits_ready
);

    localparam logic [11:0] DefMaxX = 12'(DEFAULT_MAX_X);
    localparam logic [11:0] DefMaxY = 12'(DEFAULT_MAX_Y);

    logic [11:0] max_x_q, max_y_q;
    logic        got_x_q, got_y_q;
    logic [11:0] load_val;

    logic        s1_valid_q;
    logic [11:0] s1_x_q, s1_y_q, s1_lim_x_q, s1_lim_y_q;
    logic        s1_over_x_q, s1_over_y_q;

    logic        s2_valid_q;
    logic [11:0] s2_x_q, s2_y_q;
    logic        s2_edge_x_q, s2_edge_y_q;

    // A zero limit is stored as 1 so max-1 never underflows.
    always_comb begin
        load_val = (value == 12'd0) ? 12'd1 : value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_x_q      <= DefMaxX;
            max_y_q      <= DefMaxY;
            got_x_q      <= 1'b0;
            got_y_q      <= 1'b0;
            limits_ready <= 1'b0;
        end else begin
            if (setmax_x) begin
                max_x_q <= load_val;
                got_x_q <= 1'b1;
            end
            if (setmax_y) begin
                max_y_q <= load_val;
                got_y_q <= 1'b1;
            end
            limits_ready <= (got_x_q | setmax_x) & (got_y_q | setmax_y);
        end
    end

    // Limits are snapshotted here so later loads cannot affect a sample in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_lim_x_q  <= '0;
            s1_lim_y_q  <= '0;
            s1_over_x_q <= 1'b0;
            s1_over_y_q <= 1'b0;
        end else begin
            s1_valid_q <= pos_valid;
            if (pos_valid) begin
                s1_x_q      <= xpos_in;
                s1_y_q      <= ypos_in;
                s1_lim_x_q  <= max_x_q - 12'd1;
                s1_lim_y_q  <= max_y_q - 12'd1;
                s1_over_x_q <= xpos_in >= max_x_q;
                s1_over_y_q <= ypos_in >= max_y_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            s2_edge_x_q <= 1'b0;
            s2_edge_y_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_x_q      <= s1_over_x_q ? s1_lim_x_q : s1_x_q;
                s2_y_q      <= s1_over_y_q ? s1_lim_y_q : s1_y_q;
                s2_edge_x_q <= s1_over_x_q;
                s2_edge_y_q <= s1_over_y_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos          <= '0;
            ypos          <= '0;
            edge_x        <= 1'b0;
            edge_y        <= 1'b0;
            pos_valid_out <= 1'b0;
            moved         <= 1'b0;
        end else begin
            pos_valid_out <= s2_valid_q;
            moved         <= s2_valid_q && ((s2_x_q != xpos) || (s2_y_q != ypos));
            if (s2_valid_q) begin
                xpos   <= s2_x_q;
                ypos   <= s2_y_q;
                edge_x <= s2_edge_x_q;
                edge_y <= s2_edge_y_q;
            end
        end
    end

endmodule

// File: tb/tb_mouse_limit_clamp.sv
// Randomized and directed bench for mouse_limit_clamp against a queue-based
// reference model of the clamp rules.
module tb_mouse_limit_clamp;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] value, xpos_in, ypos_in;
    logic        setmax_x, setmax_y, pos_valid;
    logic [11:0] xpos, ypos;
    logic        pos_valid_out, edge_x, edge_y, moved, limits_ready;

    mouse_limit_clamp #(
        .DEFAULT_MAX_X(800),
        .DEFAULT_MAX_Y(600)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .value        (value),
        .setmax_x     (setmax_x),
        .setmax_y     (setmax_y),
        .xpos_in      (xpos_in),
        .ypos_in      (ypos_in),
        .pos_valid    (pos_valid),
        .xpos         (xpos),
        .ypos         (ypos),
        .pos_valid_out(pos_valid_out),
        .edge_x       (edge_x),
        .edge_y       (edge_y),
        .moved        (moved),
        .limits_ready (limits_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int due;
        int x;
        int y;
        bit ex;
        bit ey;
    } item_t;

    item_t pend[$];
    int    cyc = 0;
    int    m_max_x, m_max_y, m_xpos, m_ypos;
    bit    m_got_x, m_got_y, m_ex, m_ey;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_max_x = 800;
        m_max_y = 600;
        m_got_x = 0;
        m_got_y = 0;
        m_xpos  = 0;
        m_ypos  = 0;
        m_ex    = 0;
        m_ey    = 0;
    endtask

    task automatic check_outputs();
        item_t it;
        bit    exp_pv = 0;
        bit    exp_mv = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            it     = pend.pop_front();
            exp_pv = 1;
            exp_mv = (it.x != m_xpos) || (it.y != m_ypos);
            m_xpos = it.x;
            m_ypos = it.y;
            m_ex   = it.ex;
            m_ey   = it.ey;
        end
        check_eq("pos_valid_out", int'(pos_valid_out), int'(exp_pv));
        check_eq("moved", int'(moved), int'(exp_mv));
        check_eq("xpos", int'(xpos), m_xpos);
        check_eq("ypos", int'(ypos), m_ypos);
        check_eq("edge_x", int'(edge_x), int'(m_ex));
        check_eq("edge_y", int'(edge_y), int'(m_ey));
        check_eq("limits_ready", int'(limits_ready), int'(m_got_x && m_got_y));
    endtask

    // Called at a negedge; the DUT samples these inputs at the next posedge.
    task automatic step(input bit pv, input int x, input int y,
                        input bit sx, input bit sy, input int v);
        item_t it;
        pos_valid = pv;
        xpos_in   = 12'(x);
        ypos_in   = 12'(y);
        setmax_x  = sx;
        setmax_y  = sy;
        value     = 12'(v);
        if (pv) begin
            it.due = cyc + 3;
            it.ex  = x >= m_max_x;
            it.ey  = y >= m_max_y;
            it.x   = it.ex ? m_max_x - 1 : x;
            it.y   = it.ey ? m_max_y - 1 : y;
            pend.push_back(it);
        end
        if (sx) begin
            m_max_x = (v == 0) ? 1 : v;
            m_got_x = 1;
        end
        if (sy) begin
            m_max_y = (v == 0) ? 1 : v;
            m_got_y = 1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Asserts rst mid-cycle and checks the asynchronous clear before any clock edge.
    task automatic do_reset();
        pos_valid = 0;
        setmax_x  = 0;
        setmax_y  = 0;
        rst       = 1'b1;
        #1;
        check_eq("rst_xpos", int'(xpos), 0);
        check_eq("rst_ypos", int'(ypos), 0);
        check_eq("rst_pvo", int'(pos_valid_out), 0);
        check_eq("rst_moved", int'(moved), 0);
        check_eq("rst_edge_x", int'(edge_x), 0);
        check_eq("rst_edge_y", int'(edge_y), 0);
        check_eq("rst_ready", int'(limits_ready), 0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        value     = '0;
        xpos_in   = '0;
        ypos_in   = '0;
        setmax_x  = 0;
        setmax_y  = 0;
        pos_valid = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Default limits clamp an oversized sample.
        step(1, 900, 700, 0, 0, 0);
        idle();
        idle();
        check_eq("s1_xpos", int'(xpos), 799);
        check_eq("s1_ypos", int'(ypos), 599);
        check_eq("s1_edges", int'({edge_x, edge_y}), 3);
        check_eq("s1_moved", int'(moved), 1);

        // Back-to-back samples: moved follows position changes.
        step(1, 10, 10, 0, 0, 0);
        step(1, 10, 10, 0, 0, 0);
        step(1, 11, 10, 0, 0, 0);
        check_eq("b2b_moved0", int'(moved), 1);
        idle();
        check_eq("b2b_moved1", int'(moved), 0);
        check_eq("b2b_pvo1", int'(pos_valid_out), 1);
        idle();
        check_eq("b2b_moved2", int'(moved), 1);
        check_eq("b2b_x2", int'(xpos), 11);

        // A zero Y limit becomes 1, so every y clamps to 0.
        step(0, 0, 0, 0, 1, 0);
        step(1, 3, 5, 0, 0, 0);
        idle();
        idle();
        check_eq("zero_ypos", int'(ypos), 0);
        check_eq("zero_edge_y", int'(edge_y), 1);

        // Load and sample at the same edge: old limit, then new limit.
        do_reset();
        step(1, 500, 0, 1, 0, 320);
        step(1, 500, 0, 0, 0, 0);
        idle();
        check_eq("same_edge_old", int'(xpos), 500);
        idle();
        check_eq("same_edge_new", int'(xpos), 319);

        // Both limits loaded: limits_ready rises, new clamps apply.
        do_reset();
        step(0, 0, 0, 1, 0, 640);
        check_eq("ready_half", int'(limits_ready), 0);
        step(0, 0, 0, 0, 1, 480);
        check_eq("ready_full", int'(limits_ready), 1);
        step(1, 1000, 1000, 0, 0, 0);
        idle();
        idle();
        check_eq("lim_xpos", int'(xpos), 639);
        check_eq("lim_ypos", int'(ypos), 479);

        // Reset one cycle after a sample discards it and restores defaults.
        step(1, 100, 100, 0, 0, 0);
        do_reset();
        idle();
        idle();
        check_eq("flush_pvo", int'(pos_valid_out), 0);
        step(1, 900, 700, 0, 0, 0);
        idle();
        idle();
        check_eq("flush_def_x", int'(xpos), 799);
        check_eq("flush_def_y", int'(ypos), 599);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit pv, sx, sy;
            int x, y, v;
            if (i == 300) do_reset();
            pv = $urandom_range(0, 9) < 6;
            sx = $urandom_range(0, 14) == 0;
            sy = $urandom_range(0, 14) == 0;
            case ($urandom_range(0, 3))
                0:       v = 0;
                1:       v = $urandom_range(1, 4);
                default: v = $urandom_range(0, 4095);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                x = $urandom_range(0, 4095);
                y = $urandom_range(0, 4095);
            end else begin
                x = $urandom_range(0, (m_max_x + 2 > 4095) ? 4095 : m_max_x + 2);
                y = $urandom_range(0, (m_max_y + 2 > 4095) ? 4095 : m_max_y + 2);
            end
            step(pv, x, y, sx, sy, v);
        end
        for (int i = 0; i < 4; i++) idle();
        check_eq("drained", pend.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_limit_clamp.md
MOUSE_LIMIT_CLAMP -- requirements
Module: mouse_limit_clamp

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DEFAULT_MAX_X, 800, X limit in effect from reset until the first setmax_x load.
- DEFAULT_MAX_Y, 600, Y limit in effect from reset until the first setmax_y load.
REQ-002 Ports, one per line: name  direction  width  meaning:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- value  input  12  limit value to load.
- setmax_x  input  1  load strobe: value becomes the X limit.
- setmax_y  input  1  load strobe: value becomes the Y limit.
- xpos_in  input  12  raw mouse X position.
- ypos_in  input  12  raw mouse Y position.
- pos_valid  input  1  raw position qualifier, one-cycle pulse per sample.
- xpos  output  12  clamped X position, registered.
- ypos  output  12  clamped Y position, registered.
- pos_valid_out  output  1  one-cycle pulse marking new xpos/ypos.
- edge_x  output  1  registered; set when the current xpos was clamped.
- edge_y  output  1  registered; set when the current ypos was clamped.
- moved  output  1  one-cycle pulse, coincident with pos_valid_out, when xpos or ypos changed.
- limits_ready  output  1  high once both limits have been loaded since reset.
REQ-003 One clock domain (clk); reset is asynchronous and active-high (rst).

Function
REQ-004 Internal registers max_x and max_y, 12 bits each, reset to DEFAULT_MAX_X and DEFAULT_MAX_Y.
REQ-005 setmax_x high at an edge: max_x takes value at that edge. setmax_y works the same way for max_y.
REQ-006 setmax_x and setmax_y high in the same cycle: both registers load the same value.
REQ-007 A loaded value of 0 is stored as 1, so the valid range is always non-empty.
REQ-008 Internal flags got_x and got_y set on their first load. limits_ready = got_x AND got_y, registered. Only reset clears these flags.
REQ-009 Stage 1: on pos_valid, capture xpos_in and ypos_in. Compare them against max_x-1 and max_y-1 as held before that edge.
REQ-010 Stage 2: xpos = (x >= max_x) ? max_x-1 : x, with no underflow because max_x >= 1. edge_x = 1 exactly when clamping occurred. Y is handled the same way with max_y.
REQ-011 Latency: pos_valid at edge N gives pos_valid_out high for one cycle after edge N+2.
REQ-012 Throughput: pos_valid may be asserted every cycle. Every sample produces exactly one output, in order.
REQ-013 Limit load and pos_valid at the same edge: that sample uses the old limits. The next sample uses the new limits.
REQ-014 A limit load while a sample is in stage 1 does not alter that sample's clamp result.
REQ-015 xpos, ypos, edge_x and edge_y hold their values between output pulses. A new limit never re-clamps an already-issued output.
REQ-016 moved = pos_valid_out AND (new xpos != previous xpos OR new ypos != previous ypos). The previous position is the last output, or 0,0 after reset.
REQ-017 Samples are clamped even while limits_ready = 0; the defaults apply until loads occur.

Reset
REQ-018 rst high sets these immediately, without waiting for clk:
- xpos = 0, ypos = 0.
- pos_valid_out = 0, moved = 0.
- edge_x = 0, edge_y = 0.
- limits_ready = 0, got_x = 0, got_y = 0.
- max_x = DEFAULT_MAX_X, max_y = DEFAULT_MAX_Y.
- Pipeline valids cleared.
REQ-019 A sample in flight when rst asserts is discarded and produces no pos_valid_out.
REQ-020 After rst deasserts, the first sample is accepted on the first clk edge.

Verification
REQ-021 The bench shall cover these scenarios (stimulus -> required response):
- Reset, then pos_valid with xpos_in=900, ypos_in=700 -> after 2 cycles xpos=799, ypos=599, edge_x=1, edge_y=1, moved=1.
- setmax_x with value=640, next cycle setmax_y with value=480 -> limits_ready rises after the second load. Sample 1000,1000 -> output 639,479.
- setmax_x with value=320 and pos_valid with xpos_in=500 at the same edge -> output 500 (old limit 800). The next identical sample -> output 319.
- Back-to-back pos_valid with samples 10,10 then 10,10 then 11,10 -> three pos_valid_out pulses with moved = 1, 0, 1.
- setmax_y with value=0, then sample y=5 -> ypos=0, edge_y=1.
- rst pulse one cycle after pos_valid -> no pos_valid_out, all outputs 0, limits back to 800/600.
